// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Arbitrates I-cache, D-cache load and write-through store traffic
//             onto one memory port, tracking outstanding TIDs and routing
//             completions back. Define MEM_ARB_RR_EN for round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int TID_WIDTH  = 2,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  icache_req_valid_i,
    output logic                  icache_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] icache_req_addr_i,
    input  logic                  dcache_ld_valid_i,
    output logic                  dcache_ld_ready_o,
    input  logic [ADDR_WIDTH-1:0] dcache_ld_addr_i,
    input  logic                  dcache_st_valid_i,
    output logic                  dcache_st_ready_o,
    input  logic [ADDR_WIDTH-1:0] dcache_st_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [1:0]            mem_req_src_o,
    output logic [TID_WIDTH-1:0]  mem_req_tid_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [TID_WIDTH-1:0]  mem_rsp_tid_i,
    output logic                  icache_rsp_valid_o,
    output logic                  dcache_ld_rsp_valid_o,
    output logic                  dcache_st_ack_o,
    output logic [TID_WIDTH:0]    outstanding_o,
    output logic                  err_o
);
    localparam int             OFFS     = $clog2(LINE_WIDTH / 8);
    localparam int             LINE_W   = ADDR_WIDTH - OFFS;
    localparam int             NENT     = 2 ** TID_WIDTH;
    localparam logic [1:0]     SRC_IC   = 2'd0;
    localparam logic [1:0]     SRC_LD   = 2'd1;
    localparam logic [1:0]     SRC_ST   = 2'd2;
    localparam logic [TID_WIDTH:0] CNT_ONE = 1;

    logic [NENT-1:0]       ent_valid;
    logic [1:0]            ent_src  [NENT];
    logic [LINE_W-1:0]     ent_line [NENT];

    logic                  slot_loadable;
    logic                  free_any;
    logic [TID_WIDTH-1:0]  free_tid;
    logic                  ld_hazard;
    logic [LINE_W-1:0]     ld_line;
    logic [2:0]            req;
    logic [2:0]            gnt;
    logic [1:0]            gnt_src;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic                  rsp_hit;
    logic [1:0]            rsp_src;

    assign slot_loadable = !mem_req_valid_o || mem_req_ready_i;
    assign ld_line       = dcache_ld_addr_i[ADDR_WIDTH-1:OFFS];

    // Lowest free TID, plus load-after-store hazard against table and slot.
    always_comb begin
        free_any  = 1'b0;
        free_tid  = '0;
        ld_hazard = mem_req_valid_o && (mem_req_src_o == SRC_ST) &&
                    (mem_req_addr_o[ADDR_WIDTH-1:OFFS] == ld_line);
        for (int i = NENT - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_tid = TID_WIDTH'(i);
            end
            if (ent_valid[i] && (ent_src[i] == SRC_ST) && (ent_line[i] == ld_line))
                ld_hazard = 1'b1;
        end
    end

    assign req = {dcache_st_valid_i, dcache_ld_valid_i && !ld_hazard, icache_req_valid_i}
                 & {3{!rst_i && slot_loadable && free_any}};

`ifdef MEM_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Walk from lowest to highest priority so the pointer position wins last.
    always_comb begin
        gnt  = 3'b000;
        cand = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = wrap3({1'b0, rr_ptr} + 3'(k));
            if (req[cand]) gnt = 3'b001 << cand;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)      rr_ptr <= SRC_IC;
        else if (grant) rr_ptr <= wrap3({1'b0, gnt_src} + 3'd1);
    end
`else
    always_comb begin
        gnt = 3'b000;
        if (req[2])      gnt = 3'b100;
        else if (req[1]) gnt = 3'b010;
        else if (req[0]) gnt = 3'b001;
    end
`endif

    assign grant    = |gnt;
    assign gnt_src  = gnt[2] ? SRC_ST : (gnt[1] ? SRC_LD : SRC_IC);
    assign gnt_addr = gnt[2] ? dcache_st_addr_i :
                      (gnt[1] ? dcache_ld_addr_i : icache_req_addr_i);

    assign icache_req_ready_o = gnt[0];
    assign dcache_ld_ready_o  = gnt[1];
    assign dcache_st_ready_o  = gnt[2];

    assign rsp_hit = !rst_i && mem_rsp_valid_i && ent_valid[mem_rsp_tid_i];
    assign rsp_src = ent_src[mem_rsp_tid_i];

    assign icache_rsp_valid_o    = rsp_hit && (rsp_src == SRC_IC);
    assign dcache_ld_rsp_valid_o = rsp_hit && (rsp_src == SRC_LD);
    assign dcache_st_ack_o       = rsp_hit && (rsp_src == SRC_ST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid       <= '0;
            mem_req_valid_o <= 1'b0;
            outstanding_o   <= '0;
            err_o           <= 1'b0;
        end else begin
            if (grant) begin
                ent_valid[free_tid] <= 1'b1;
                ent_src[free_tid]   <= gnt_src;
                ent_line[free_tid]  <= gnt_addr[ADDR_WIDTH-1:OFFS];
                mem_req_valid_o     <= 1'b1;
                mem_req_addr_o      <= gnt_addr;
                mem_req_src_o       <= gnt_src;
                mem_req_tid_o       <= free_tid;
            end else if (mem_req_ready_i) begin
                mem_req_valid_o <= 1'b0;
            end
            // Granted TID is always free, so it never collides with the freed one.
            if (rsp_hit)
                ent_valid[mem_rsp_tid_i] <= 1'b0;
            if (mem_rsp_valid_i && !ent_valid[mem_rsp_tid_i])
                err_o <= 1'b1;
            if (grant && !rsp_hit)
                outstanding_o <= outstanding_o + CNT_ONE;
            else if (!grant && rsp_hit)
                outstanding_o <= outstanding_o - CNT_ONE;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Self-checking bench: directed vector table, corner sequences and
//             randomized traffic against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ic_v, ld_v, st_v, mem_rdy, rsp_v;
    logic [63:0] ic_a, ld_a, st_a;
    logic [1:0]  rsp_tid;
    logic        ic_r, ld_r, st_r, mreq_v, ic_rsp, ld_rsp, st_ack, err;
    logic [63:0] mreq_addr;
    logic [1:0]  mreq_src, mreq_tid;
    logic [2:0]  outst;

    cache_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .icache_req_valid_i(ic_v), .icache_req_ready_o(ic_r), .icache_req_addr_i(ic_a),
        .dcache_ld_valid_i(ld_v), .dcache_ld_ready_o(ld_r), .dcache_ld_addr_i(ld_a),
        .dcache_st_valid_i(st_v), .dcache_st_ready_o(st_r), .dcache_st_addr_i(st_a),
        .mem_req_valid_o(mreq_v), .mem_req_ready_i(mem_rdy), .mem_req_addr_o(mreq_addr),
        .mem_req_src_o(mreq_src), .mem_req_tid_o(mreq_tid),
        .mem_rsp_valid_i(rsp_v), .mem_rsp_tid_i(rsp_tid),
        .icache_rsp_valid_o(ic_rsp), .dcache_ld_rsp_valid_o(ld_rsp), .dcache_st_ack_o(st_ack),
        .outstanding_o(outst), .err_o(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a set of in-flight transactions and one output slot.
    bit        m_known = 1'b0;
    bit        m_valid [4];
    bit [1:0]  m_src   [4];
    bit [59:0] m_line  [4];
    bit        m_sv, m_err;
    bit [63:0] m_sa;
    bit [1:0]  m_ss, m_st;
    int        m_ptr;

    logic [2:0]  s_rdy, s_pl, s_out;
    logic        s_mv, s_err;
    logic [63:0] s_addr;
    logic [1:0]  s_src, s_tid;

    typedef struct {
        bit        rst, ic_v, ld_v, st_v, mrdy, rsp_v;
        bit [1:0]  rsp_tid;
        bit [31:0] ic_a, ld_a, st_a;
        bit [2:0]  e_rdy, e_pl;
        bit        e_mv;
        bit [1:0]  e_src, e_tid;
        bit [2:0]  e_out;
        bit        e_err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int       ftid, g, cnt;
        bit       haz, hit, bad;
        bit [2:0] cand, e_rdy, e_pl;
        bit [63:0] gaddr;
        ftid = -1; g = -1; cnt = 0;
        haz = m_sv && (m_ss == 2'd2) && (m_sa[63:4] == ld_a[63:4]);
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_src[i] == 2'd2 && m_line[i] == ld_a[63:4]) haz = 1'b1;
            if (!m_valid[i] && ftid < 0) ftid = i;
        end
        cand = {st_v, ld_v & ~haz, ic_v};
        if (!rst && (!m_sv || mem_rdy) && ftid >= 0) begin
`ifdef MEM_ARB_RR_EN
            for (int k = 0; k < 3; k++)
                if (g < 0 && cand[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
`else
            for (int k = 2; k >= 0; k--)
                if (g < 0 && cand[k]) g = k;
`endif
        end
        e_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        hit   = !rst && rsp_v && m_valid[rsp_tid];
        bad   = !rst && rsp_v && !m_valid[rsp_tid];
        e_pl  = hit ? (3'b001 << m_src[rsp_tid]) : 3'b000;
        if (m_known) begin
            chk("ready", s_rdy, e_rdy);
            chk("rsp_pulse", s_pl, e_pl);
            chk("mem_req_valid", s_mv, m_sv);
            if (m_sv) begin
                chk("mem_req_addr", s_addr, m_sa);
                chk("mem_req_src_tid", {s_src, s_tid}, {m_ss, m_st});
            end
            for (int i = 0; i < 4; i++) cnt += int'(m_valid[i]);
            chk("outstanding", s_out, 64'(cnt));
            chk("err", s_err, m_err);
        end
        if (rst) begin
            m_valid = '{default: 1'b0};
            m_sv = 1'b0; m_err = 1'b0; m_ptr = 0; m_known = 1'b1;
        end else begin
            if (g >= 0) begin
                gaddr = (g == 0) ? ic_a : ((g == 1) ? ld_a : st_a);
                m_valid[ftid] = 1'b1; m_src[ftid] = 2'(g); m_line[ftid] = gaddr[63:4];
                m_sv = 1'b1; m_sa = gaddr; m_ss = 2'(g); m_st = 2'(ftid);
                m_ptr = (g + 1) % 3;
            end else if (mem_rdy) begin
                m_sv = 1'b0;
            end
            if (hit) m_valid[rsp_tid] = 1'b0;
            if (bad) m_err = 1'b1;
        end
    endtask

    // Called at posedge+1: sample at the following negedge, then advance a clock.
    task automatic cycle();
        #4;
        s_rdy  = {st_r, ld_r, ic_r};
        s_pl   = {st_ack, ld_rsp, ic_rsp};
        s_mv   = mreq_v; s_addr = mreq_addr; s_src = mreq_src; s_tid = mreq_tid;
        s_out  = outst;  s_err  = err;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rst = 1'b0; ic_v = 1'b0; ld_v = 1'b0; st_v = 1'b0;
        mem_rdy = 1'b1; rsp_v = 1'b0; rsp_tid = 2'd0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) begin
            idle();
            for (int i = 3; i >= 0; i--)
                if (m_valid[i]) begin rsp_v = 1'b1; rsp_tid = 2'(i); end
            cycle();
        end
    endtask

    function automatic logic [63:0] raddr();
        return 64'h8000_0000 + 64'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
    endfunction

    localparam bit [31:0] A  = 32'h8000_0040;
    localparam bit [31:0] S  = 32'h8000_0100;
    localparam bit [31:0] L  = 32'h8000_010C;
    localparam bit [31:0] L2 = 32'h8000_0110;

    initial begin
        logic [2:0] exp_rdy;
        int cnt, pick;
        //           rst ic ld st rdy rv tid  ic_a ld_a st_a  e_rdy  e_pl  mv src tid out err
        tbl.push_back('{1, 1, 1, 1, 1, 0, 0,  A,  L,  S,  3'b000, 3'b000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0,  A,  0,  0,  3'b001, 3'b000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  3'b000, 3'b000, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0,  0,  0,  0,  3'b000, 3'b000, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0,  0,  0,  0,  3'b000, 3'b001, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0,  0,  0,  0,  3'b000, 3'b000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 0, 0,  0,  0,  S,  3'b100, 3'b000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0,  0,  L,  0,  3'b000, 3'b000, 1, 2, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0,  0,  L,  0,  3'b000, 3'b000, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 1, 0,  0,  L,  0,  3'b000, 3'b100, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0,  0,  L,  0,  3'b010, 3'b000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0,  0,  0,  0,  3'b000, 3'b000, 1, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 0, 0,  0,  0,  S,  3'b100, 3'b000, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0,  0,  L2, 0,  3'b010, 3'b000, 1, 2, 1, 2, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0,  0,  0,  0,  3'b000, 3'b000, 1, 1, 2, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 1,  0,  0,  0,  3'b000, 3'b100, 0, 0, 0, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 0,  0,  0,  0,  3'b000, 3'b010, 0, 0, 0, 2, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1, 2,  0,  0,  0,  3'b000, 3'b010, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0,  0,  0,  0,  3'b000, 3'b000, 0, 0, 0, 0, 0});

        idle(); rst = 1'b1; ic_a = '0; ld_a = '0; st_a = '0;
        @(posedge clk); #1;
        cycle(); cycle();

        foreach (tbl[i]) begin
            rst = tbl[i].rst; ic_v = tbl[i].ic_v; ld_v = tbl[i].ld_v; st_v = tbl[i].st_v;
            mem_rdy = tbl[i].mrdy; rsp_v = tbl[i].rsp_v; rsp_tid = tbl[i].rsp_tid;
            ic_a = 64'(tbl[i].ic_a); ld_a = 64'(tbl[i].ld_a); st_a = 64'(tbl[i].st_a);
            cycle();
            chk($sformatf("row%0d_ready", i), s_rdy, tbl[i].e_rdy);
            chk($sformatf("row%0d_pulse", i), s_pl, tbl[i].e_pl);
            chk($sformatf("row%0d_mreq_valid", i), s_mv, tbl[i].e_mv);
            if (tbl[i].e_mv)
                chk($sformatf("row%0d_src_tid", i), {s_src, s_tid}, {tbl[i].e_src, tbl[i].e_tid});
            chk($sformatf("row%0d_outstanding", i), s_out, tbl[i].e_out);
            chk($sformatf("row%0d_err", i), s_err, tbl[i].e_err);
        end

        // Grant order with all requesters busy and immediate completions.
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
        ic_v = 1'b1; ld_v = 1'b1; st_v = 1'b1;
        ic_a = 64'h8000_0040; ld_a = 64'h8000_0300; st_a = 64'h8000_0100;
        for (int k = 0; k < 6; k++) begin
            rsp_v = mreq_v; rsp_tid = mreq_v ? mreq_tid : 2'd0;
`ifdef MEM_ARB_RR_EN
            exp_rdy = 3'b001 << (k % 3);
`else
            exp_rdy = 3'b100;
`endif
            cycle();
            chk($sformatf("order_grant%0d", k), s_rdy, exp_rdy);
        end
        drain();

        // Fill the table, then free one TID and watch it come back a cycle later.
        idle();
        for (int k = 0; k < 4; k++) begin
            ic_v = 1'b1; ic_a = 64'h8000_1000 + 64'(k * 16); cycle();
        end
        ic_v = 1'b1; ld_v = 1'b1; st_v = 1'b1; ld_a = 64'h8000_2000; st_a = 64'h8000_3000;
        cycle();
        chk("full_ready", s_rdy, 3'b000);
        chk("full_count", s_out, 3'd4);
        rsp_v = 1'b1; rsp_tid = 2'd2; cycle();
        chk("free_cycle_ready", s_rdy, 3'b000);
        chk("free_cycle_pulse", s_pl, 3'b001);
        rsp_v = 1'b0; cycle();
        chk("grant_after_free", s_rdy != 3'b000, 1'b1);
        chk("count_after_free", s_out, 3'd3);
        ic_v = 1'b0; ld_v = 1'b0; st_v = 1'b0; cycle();
        chk("reuse_tid", {s_mv, s_tid}, {1'b1, 2'd2});
        chk("refill_count", s_out, 3'd4);
        drain();

        // Backpressure holds the slot; a stray response sets the sticky error.
        idle(); mem_rdy = 1'b0; ic_v = 1'b1; ic_a = 64'h8000_0200; cycle();
        ic_v = 1'b0; st_v = 1'b1; st_a = 64'h8000_0400;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_ready", s_rdy, 3'b000);
            chk("stall_payload", {s_mv, s_addr, s_src, s_tid}, {1'b1, 64'h8000_0200, 2'd0, 2'd0});
        end
        st_v = 1'b0; mem_rdy = 1'b1; rsp_v = 1'b1; rsp_tid = 2'd3; cycle();
        chk("bad_rsp_pulse", s_pl, 3'b000);
        rsp_v = 1'b0; cycle();
        chk("err_set", s_err, 1'b1);
        rsp_v = 1'b1; rsp_tid = 2'd0; cycle();
        chk("err_sticky", {s_err, s_pl}, {1'b1, 3'b001});
        rsp_v = 1'b0; rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("err_cleared", {s_err, s_out, s_mv}, {1'b0, 3'd0, 1'b0});

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            ic_v    = ($urandom_range(0, 1) == 1);
            ld_v    = ($urandom_range(0, 1) == 1);
            st_v    = ($urandom_range(0, 1) == 1);
            mem_rdy = ($urandom_range(0, 3) != 0);
            ic_a = raddr(); ld_a = raddr(); st_a = raddr();
            rsp_v = 1'b0; rsp_tid = 2'd0;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 19) == 0) begin
                    rsp_v = 1'b1; rsp_tid = 2'($urandom_range(0, 3));
                end else begin
                    cnt = 0;
                    for (int i = 0; i < 4; i++) cnt += int'(m_valid[i]);
                    if (cnt > 0) begin
                        pick = $urandom_range(0, cnt - 1);
                        for (int i = 0; i < 4; i++)
                            if (m_valid[i]) begin
                                if (pick == 0) begin rsp_v = 1'b1; rsp_tid = 2'(i); end
                                pick--;
                            end
                    end
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 64, width of the request address.
REQ-002 Parameter: TID_WIDTH, default 2, transaction-ID width; the outstanding table has 2**TID_WIDTH entries.
REQ-003 Parameter: LINE_WIDTH, default 128, cache line width in bits; line address = addr[ADDR_WIDTH-1:$clog2(LINE_WIDTH/8)].
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 icache_req_valid_i / icache_req_ready_o / icache_req_addr_i  in/out/in  1/1/ADDR_WIDTH  I-cache refill request (src 0).
REQ-007 dcache_ld_valid_i / dcache_ld_ready_o / dcache_ld_addr_i  in/out/in  1/1/ADDR_WIDTH  D-cache load refill request (src 1).
REQ-008 dcache_st_valid_i / dcache_st_ready_o / dcache_st_addr_i  in/out/in  1/1/ADDR_WIDTH  write-through store from write buffer (src 2).
REQ-009 mem_req_valid_o / mem_req_ready_i  out/in  1/1  registered memory request handshake.
REQ-010 mem_req_addr_o / mem_req_src_o / mem_req_tid_o  out  ADDR_WIDTH/2/TID_WIDTH  request payload.
REQ-011 mem_rsp_valid_i / mem_rsp_tid_i  in  1/TID_WIDTH  completion of one transaction.
REQ-012 icache_rsp_valid_o / dcache_ld_rsp_valid_o / dcache_st_ack_o  out  1 each  routed completion pulses.
REQ-013 outstanding_o  out  TID_WIDTH+1  number of valid table entries.
REQ-014 err_o  out  1  sticky: response received for an unallocated TID.

Function
REQ-015 Output slot: a single register; it SHALL load a new grant only when mem_req_valid_o==0 or mem_req_ready_i==1 in that cycle; payload SHALL remain stable while valid and not ready.
REQ-016 Grant eligibility: slot loadable AND at least one free TID AND requester valid AND (for src 1) no hazard.
REQ-017 Exactly one requester ready_o SHALL be high in a grant cycle, combinationally; a transfer occurs when valid&ready.
REQ-018 On grant, the lowest-index free TID SHALL be allocated; its entry stores {valid=1, src, line address}; the slot is loaded the next edge (latency 1 cycle request-to-mem_req_valid_o).
REQ-019 Hazard: a load refill SHALL be blocked while any valid entry or the output slot holds src 2 with an equal line address; other requesters remain eligible.
REQ-020 Response: mem_rsp_valid_i with a valid entry SHALL pulse the output selected by the entry's src in the same cycle and clear the entry on the next edge.
REQ-021 Response to an invalid entry SHALL produce no routed pulse and SHALL set err_o.
REQ-022 Simultaneous free and allocate: allocation uses registered table state; the TID freed this cycle is not reused until the following cycle.
REQ-023 Table full (outstanding_o == 2**TID_WIDTH): all ready_o low; mem_req_valid_o may still drain.
REQ-024 outstanding_o SHALL count +1 on allocation, -1 on valid response, unchanged when both occur in one cycle.

Reset
REQ-025 With rst_i high at an edge: all entries invalid, mem_req_valid_o=0, outstanding_o=0, err_o=0, round-robin pointer=src 0, routed pulses 0.
REQ-026 Reset mid-operation discards in-flight transactions; later responses for their TIDs set err_o per REQ-021.
REQ-027 All ready_o SHALL be 0 while rst_i is high.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: round-robin among src 0..2; after a grant to src k, highest priority moves to src (k+1) mod 3.
REQ-029 MEM_ARB_RR_EN undefined: fixed priority src 2 > src 1 > src 0; pointer logic not built.

Verification
REQ-030 Reset, then single icache request addr 0x8000_0040 -> next cycle mem_req_valid_o=1, tid=0, src=0; response tid 0 -> icache_rsp_valid_o pulse, outstanding_o back to 0.
REQ-031 All three valid continuously, mem_req_ready_i=1, RR enabled, responses immediate -> grant order src 0,1,2,0,1,2; RR disabled -> src 2 granted every cycle while valid.
REQ-032 Store 0x8000_0100 outstanding, load 0x8000_010C requested -> dcache_ld_ready_o=0 until store acked, then load granted next cycle; load 0x8000_0110 not blocked.
REQ-033 Four grants without responses (TID_WIDTH=2) -> outstanding_o=4, all ready_o low; response tid 2 -> next grant uses tid 2 one cycle later, not in the response cycle.
REQ-034 mem_req_ready_i held low 5 cycles -> addr/src/tid stable, no new grant; response on unallocated tid 3 -> err_o=1 until reset.
